spn_req_sequencer: RTL and testbench

Request front-end sitting directly upstream of the SPN cipher core. Accepts encrypt/decrypt requests over a valid/ready handshake and buffers them in a small FIFO. Issues them one at a time to the core's opcode/in_data/key inputs, waits for the core's valid code (bounded by a timeout) and returns each result with a status over a second valid/ready handshake. Exactly one request is in flight at the core at any time.

---
 rtl/spn_pkg.sv | 32 +++
 rtl/spn_req_fifo.sv | 45 ++++
 rtl/spn_req_sequencer.sv | 128 ++++++++++++
 tb/tb_spn_req_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spn_pkg.sv
// Shared encodings and request record for the SPN request sequencer and its FIFO.
package spn_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  localparam logic [1:0] VLD_IDLE = 2'b00;
  localparam logic [1:0] VLD_ENC  = 2'b01;
  localparam logic [1:0] VLD_DEC  = 2'b10;
  localparam logic [1:0] VLD_ERR  = 2'b11;

  localparam logic [1:0] ST_TIMEOUT = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } seq_state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] data;
    logic [31:0] key;
  } spn_req_t;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/spn_req_fifo.sv
// DEPTH-entry synchronous FIFO of requests; pointers carry one extra wrap bit.
module spn_req_fifo
  import spn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  spn_req_t push_data,
  input  logic     pop,
  output spn_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  spn_req_t    mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spn_req_sequencer.sv
// Buffers cipher requests and issues them one at a time to the SPN core,
// returning each result (or timeout/error status) over a valid/ready handshake.
module spn_req_sequencer
  import spn_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_data,
  input  logic [31:0] req_key,
  output logic [1:0]  opcode,
  output logic [15:0] in_data,
  output logic [31:0] key,
  input  logic [15:0] out_data,
  input  logic [1:0]  valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        stray_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  spn_req_t      head;
  spn_req_t      push_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign push_req = '{op: req_op, data: req_data, key: req_key};
  assign push     = req_valid && !fifo_full;
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign cnt_inc  = cnt + CNT_ONE;

  spn_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      opcode     <= OP_NOP;
      in_data    <= '0;
      key        <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_TIMEOUT;
      stray_err  <= 1'b0;
    end else begin
      if ((valid != VLD_IDLE) && (state != S_WAIT))
        stray_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (op_is_legal(head.op)) begin
              opcode  <= head.op;
              in_data <= head.data;
              key     <= head.key;
              cnt     <= '0;
              state   <= S_WAIT;
            end else begin
              // illegal ops never reach the core
              rsp_data   <= '0;
              rsp_status <= ST_ERR;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          opcode <= OP_NOP;
          if (valid != VLD_IDLE) begin
            rsp_data   <= out_data;
            rsp_status <= valid;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              rsp_data   <= '0;
              rsp_status <= ST_TIMEOUT;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spn_req_sequencer.sv
// Directed bench for spn_req_sequencer with a transaction-level model and a bench-side core responder.
module tb_spn_req_sequencer;
  import spn_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [31:0] req_key;
  logic [1:0]  opcode;
  logic [15:0] in_data;
  logic [31:0] key;
  logic [15:0] out_data;
  logic [1:0]  valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        stray_err;

  spn_req_sequencer #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_key   (req_key),
    .opcode    (opcode),
    .in_data   (in_data),
    .key       (key),
    .out_data  (out_data),
    .valid     (valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_status(rsp_status),
    .busy      (busy),
    .stray_err (stray_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  status;
  } rsp_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  spn_req_t iss_q[$];
  rsp_t     exp_q[$];
  int       acc_cycs[$];
  int       issue_cycs[$];
  int       rise_cycs[$];
  rsp_t     last_rsp;

  int          core_lat    = 4;
  logic        core_silent = 1'b0;
  logic [15:0] core_mask   = 16'h0000;
  int          stray_cnt   = 0;
  logic        stray_test  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Expected response from the request alone: illegal -> error, silent core -> timeout
  function automatic rsp_t model_rsp(input logic [1:0] op, input logic [15:0] data);
    rsp_t r;
    if (op != 2'b01 && op != 2'b10) r = '{data: 16'h0000, status: 2'b11};
    else if (core_silent)           r = '{data: 16'h0000, status: 2'b00};
    else                            r = '{data: data ^ core_mask, status: op};
    return r;
  endfunction

  // Core model: answers core_lat cycles after the opcode cycle with valid = issued op
  logic [1:0]  rc_op;
  logic [15:0] rc_data;
  logic        rc_abort;
  int          stray_seen = 0;
  initial begin
    valid    = 2'b00;
    out_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && opcode != 2'b00 && !core_silent) begin
        rc_op    = opcode;
        rc_data  = in_data;
        rc_abort = 1'b0;
        for (int i = 0; i < core_lat; i++) begin
          @(posedge clk);
          if (!reset) rc_abort = 1'b1;
        end
        #1;
        if (!rc_abort && reset) begin
          valid    = rc_op;
          out_data = rc_data ^ core_mask;
          @(posedge clk); #1;
          valid    = 2'b00;
          out_data = 16'h0000;
        end
      end else if (stray_cnt != stray_seen) begin
        stray_seen++;
        @(posedge clk); #1;
        valid = 2'b01;
        @(posedge clk); #1;
        valid = 2'b00;
      end
    end
  end

  // Compare process
  logic     prev_op_nz = 1'b0;
  logic     prev_rv    = 1'b0;
  logic     in_flight  = 1'b0;
  spn_req_t cur;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_op_nz = 1'b0;
      prev_rv    = 1'b0;
      in_flight  = 1'b0;
    end else begin
      if (opcode != 2'b00) begin
        check("opcode_single_cycle", prev_op_nz, 1'b0);
        if (iss_q.size() == 0) check("opcode_unexpected", opcode, 2'b00);
        else begin
          cur = iss_q.pop_front();
          check("issue", {opcode, in_data, key}, cur);
          in_flight = 1'b1;
          issue_cycs.push_back(cyc);
        end
      end
      prev_op_nz = (opcode != 2'b00);
      if (in_flight) check("operand_hold", {in_data, key}, {cur.data, cur.key});
      if (exp_q.size() != 0) check("busy", busy, 1'b1);
      if (!stray_test) check("stray_err", stray_err, 1'b0);
      if (rsp_valid) begin
        if (!prev_rv) rise_cycs.push_back(cyc);
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          check("rsp", {rsp_data, rsp_status}, exp_q[0]);
          if (rsp_ready) begin
            last_rsp = {rsp_data, rsp_status};
            void'(exp_q.pop_front());
            in_flight = 1'b0;
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [31:0] k);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_key   = k;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) acc_cycs.push_back(cyc);
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check("send_accept", acc, 1'b1);
    if (acc) begin
      exp_q.push_back(model_rsp(op, data));
      if (op == 2'b01 || op == 2'b10) iss_q.push_back('{op: op, data: data, key: k});
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_cycs.delete();
    issue_cycs.delete();
    rise_cycs.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},  req_ready,  1'b1);
    check({tag, "_opcode"},     opcode,     2'b00);
    check({tag, "_in_data"},    in_data,    16'h0);
    check({tag, "_key"},        key,        32'h0);
    check({tag, "_rsp_valid"},  rsp_valid,  1'b0);
    check({tag, "_rsp_data"},   rsp_data,   16'h0);
    check({tag, "_rsp_status"}, rsp_status, 2'b00);
    check({tag, "_busy"},       busy,       1'b0);
    check({tag, "_stray_err"},  stray_err,  1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 16'h0;
    req_key   = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single encrypt, core latency 4
    clear_logs();
    core_lat  = 4;
    core_mask = 16'h1234 ^ 16'hBEEF;
    send(2'b01, 16'h1234, 32'hA5A5_0F0F);
    wait_drain("t1", 50);
    check("t1_issue_lat", issue_cycs[0] - acc_cycs[0], 2);
    check("t1_rsp_lat",   rise_cycs[0] - issue_cycs[0], 5);
    check("t1_rsp_data",   last_rsp.data,   16'hBEEF);
    check("t1_rsp_status", last_rsp.status, 2'b01);

    // Five requests with downstream stalled
    clear_logs();
    core_lat  = 2;
    core_mask = 16'h00FF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send((i % 2 == 1) ? 2'b10 : 2'b01, 16'h1000 + 16'(i), 32'hC0DE_0000 + 32'(i));
    @(negedge clk);
    check("t2_full_ready",  req_ready, 1'b0);
    check("t2_accept_span", acc_cycs[4] - acc_cycs[0], 4);
    repeat (10) @(negedge clk);
    check("t2_rsp_held",  rsp_valid, 1'b1);
    check("t2_still_full", req_ready, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain("t2", 100);
    check("t2_issued", issue_cycs.size(), 5);
    check("t2_spacing", issue_cycs[4] - issue_cycs[3], 5);

    // Silent core: two timeouts
    clear_logs();
    core_silent = 1'b1;
    send(2'b01, 16'h0001, 32'h1111_2222);
    send(2'b01, 16'h0002, 32'h3333_4444);
    wait_drain("t3", 100);
    check("t3_wait_cycles", rise_cycs[0] - issue_cycs[0], 16);
    check("t3_next_issue",  issue_cycs[1] - rise_cycs[0], 2);
    check("t3_last_rsp",    last_rsp, 18'h0);

    // Core valid on the expiry cycle wins
    clear_logs();
    core_silent = 1'b0;
    core_lat    = 15;
    core_mask   = 16'h0F0F;
    send(2'b10, 16'h5A5A, 32'hDEAD_BEEF);
    wait_drain("t4", 60);
    check("t4_wait_cycles", rise_cycs[0] - issue_cycs[0], 16);
    check("t4_last_rsp",    last_rsp, {16'h5555, 2'b10});

    // Illegal ops
    clear_logs();
    core_lat = 2;
    send(2'b11, 16'hAAAA, 32'h0);
    send(2'b00, 16'hBBBB, 32'h1);
    wait_drain("t5", 30);
    check("t5_rsp_lat",  rise_cycs[0] - acc_cycs[0], 2);
    check("t5_no_issue", issue_cycs.size(), 0);
    check("t5_last_rsp", last_rsp, {16'h0000, 2'b11});

    // Reset during WAIT with two queued
    clear_logs();
    core_lat  = 10;
    core_mask = 16'h0000;
    send(2'b01, 16'h0A0A, 32'h1);
    send(2'b01, 16'h0B0B, 32'h2);
    send(2'b10, 16'h0C0C, 32'h3);
    n = 0;
    while (issue_cycs.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_issued", issue_cycs.size(), 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("t6");
    iss_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_busy",   busy, 1'b0);
    check("t6_no_rsp", rise_cycs.size(), 0);
    @(posedge clk); #1;

    // Stray core valid in IDLE
    stray_test = 1'b1;
    stray_cnt++;
    n = 0;
    while (valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t7_valid_pulse",  valid,     2'b01);
    check("t7_stray_before", stray_err, 1'b0);
    @(negedge clk);
    check("t7_stray_set", stray_err, 1'b1);
    repeat (5) @(negedge clk);
    check("t7_stray_sticky", stray_err, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t7_stray_cleared", stray_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stray_test = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
